// File: rtl/pdp1_pkg.sv
// Shared PDP-1 skip-unit definitions: flag command encodings, skip-mask
// bit positions and field ranges (PDP bit numbering, bit 0 = MSB).
package pdp1_pkg;

  typedef enum logic [1:0] {
    FL_NOP = 2'b00,
    FL_CLR = 2'b01,
    FL_SET = 2'b10,
    FL_RSV = 2'b11
  } fl_cmd_e;

  localparam int SK_IO_NZ = 0;
  localparam int SK_IO_P  = 1;
  localparam int SK_OV    = 2;
  localparam int SK_AC_M  = 3;
  localparam int SK_AC_P  = 4;
  localparam int SK_AC_Z  = 5;

  localparam int SK_SW_HI = 6;
  localparam int SK_SW_LO = 8;
  localparam int SK_PF_HI = 9;
  localparam int SK_PF_LO = 11;

  localparam logic [2:0] SEL_ALL  = 3'd7;
  localparam logic [2:0] SEL_NONE = 3'd0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RESULT = 1'b1
  } skp_state_e;

endpackage

// File: rtl/pdp1_flg_sel.sv
// Maps a 3-bit select and an N-bit flag/switch vector to the skip-group
// "condition not met" bit: 0 -> 0, 7 -> not all set, 1..N -> not bit, >N -> 0.
module pdp1_flg_sel
  import pdp1_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [2:0] sel,
  input  logic [N:1] vec,
  output logic       nmet
);

  always_comb begin
    nmet = 1'b0;
    if (sel == SEL_ALL) begin
      nmet = ~(&vec);
    end else begin
      for (int i = 1; i <= N; i++) begin
        if (sel == 3'(i)) nmet = ~vec[i];
      end
    end
  end

endmodule

// File: rtl/pdp1_skp_unit.sv
// Registered PDP-1 skip unit: program flags, sense-switch sync and one-cycle
// skip evaluation. Optional overflow-clear pulse under PDP1_SKP_OVCLR_EN.
module pdp1_skp_unit
  import pdp1_pkg::*;
#(
  parameter int NFLAGS   = 6,
  parameter int NSW      = 6,
  parameter int MODEL_1D = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sk_req,
  input  logic [0:11]       sk_mask,
  input  logic              sk_i,
  input  logic [0:17]       sk_ac,
  input  logic [0:17]       sk_io,
  input  logic              sk_ov,
  input  logic [NSW:1]      sk_sw,
  input  logic [1:0]        fl_cmd,
  input  logic [2:0]        fl_n,
  output logic              sk_ack,
  output logic              sk_skp,
  output logic              sk_ovclr,
  output logic [NFLAGS:1]   sk_pf
);

  logic [NSW:1] sw_m;
  logic [NSW:1] sw_s;
  logic         pf_nmet;
  logic         sw_nmet;
  logic         io_nz_term;
  logic         skip_or;
  skp_state_e   state;

  always_ff @(posedge clk) begin
    if (rst) begin
      sk_pf <= '0;
    end else if (fl_cmd == FL_CLR || fl_cmd == FL_SET) begin
      if (fl_n == SEL_ALL) begin
        sk_pf <= {NFLAGS{fl_cmd == FL_SET}};
      end else begin
        for (int i = 1; i <= NFLAGS; i++) begin
          if (fl_n == 3'(i)) sk_pf[i] <= (fl_cmd == FL_SET);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= sk_sw;
      sw_s <= sw_m;
    end
  end

  // Flag term sees the pre-edge register, so a same-cycle fl_cmd is not visible.
  pdp1_flg_sel #(.N(NFLAGS)) u_pf_sel (
    .sel  (sk_mask[SK_PF_HI:SK_PF_LO]),
    .vec  (sk_pf),
    .nmet (pf_nmet)
  );

  pdp1_flg_sel #(.N(NSW)) u_sw_sel (
    .sel  (sk_mask[SK_SW_HI:SK_SW_LO]),
    .vec  (sw_s),
    .nmet (sw_nmet)
  );

  assign io_nz_term = (MODEL_1D != 0) && sk_mask[SK_IO_NZ] && (sk_io[1:17] != '0);

  assign skip_or = (sk_mask[SK_IO_P] & ~sk_io[0])
                 | (sk_mask[SK_OV]   & ~sk_ov)
                 | (sk_mask[SK_AC_M] &  sk_ac[0])
                 | (sk_mask[SK_AC_P] & ~sk_ac[0])
                 | (sk_mask[SK_AC_Z] & (sk_ac == '0))
                 | pf_nmet
                 | sw_nmet
                 | io_nz_term;

  // RESULT lasts one cycle per request; back-to-back requests stay in RESULT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sk_ack <= 1'b0;
      sk_skp <= 1'b0;
`ifdef PDP1_SKP_OVCLR_EN
      sk_ovclr <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE:   state <= sk_req ? ST_RESULT : ST_IDLE;
        ST_RESULT: state <= sk_req ? ST_RESULT : ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
      sk_ack <= sk_req;
      sk_skp <= sk_req & (skip_or ^ sk_i);
`ifdef PDP1_SKP_OVCLR_EN
      sk_ovclr <= sk_req & sk_mask[SK_OV];
`endif
    end
  end

`ifndef PDP1_SKP_OVCLR_EN
  assign sk_ovclr = 1'b0;
`endif

endmodule

// File: tb/tb_pdp1_skp_unit.sv
// Directed self-checking bench for pdp1_skp_unit (MODEL_1D=1, 6 flags, 6 switches).
// Overflow-clear expectations follow PDP1_SKP_OVCLR_EN when it is defined.
module tb_pdp1_skp_unit;

`ifdef PDP1_SKP_OVCLR_EN
  localparam logic OVCLR_EN = 1'b1;
`else
  localparam logic OVCLR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sk_req;
  logic [0:11] sk_mask;
  logic        sk_i;
  logic [0:17] sk_ac;
  logic [0:17] sk_io;
  logic        sk_ov;
  logic [6:1]  sk_sw;
  logic [1:0]  fl_cmd;
  logic [2:0]  fl_n;
  logic        sk_ack;
  logic        sk_skp;
  logic        sk_ovclr;
  logic [6:1]  sk_pf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pdp1_skp_unit #(.NFLAGS(6), .NSW(6), .MODEL_1D(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .sk_req   (sk_req),
    .sk_mask  (sk_mask),
    .sk_i     (sk_i),
    .sk_ac    (sk_ac),
    .sk_io    (sk_io),
    .sk_ov    (sk_ov),
    .sk_sw    (sk_sw),
    .fl_cmd   (fl_cmd),
    .fl_n     (fl_n),
    .sk_ack   (sk_ack),
    .sk_skp   (sk_skp),
    .sk_ovclr (sk_ovclr),
    .sk_pf    (sk_pf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs and new inputs are away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request cycle; result checked right after the accepting edge.
  task automatic req_chk(input string tag, input logic [11:0] mask, input logic inv,
                         input logic exp_skp, input logic exp_ovclr);
    sk_req  = 1'b1;
    sk_mask = mask;
    sk_i    = inv;
    step();
    sk_req = 1'b0;
    chk({tag, "_ack"}, 32'(sk_ack), 32'd1);
    chk({tag, "_skp"}, 32'(sk_skp), 32'(exp_skp));
    chk({tag, "_ovclr"}, 32'(sk_ovclr), 32'(exp_ovclr));
  endtask

  initial begin
    rst = 1'b1; sk_req = 1'b0; sk_mask = '0; sk_i = 1'b0;
    sk_ac = 18'o000001; sk_io = 18'o400000; sk_ov = 1'b1;
    sk_sw = '0; fl_cmd = 2'b00; fl_n = 3'd0;
    #1;
    step(); step();
    rst = 1'b0;
    chk("rst_pf", 32'(sk_pf), 32'h0);
    chk("rst_ack", 32'(sk_ack), 32'd0);
    chk("rst_skp", 32'(sk_skp), 32'd0);
    chk("rst_ovclr", 32'(sk_ovclr), 32'd0);

    // Flag set/clear
    fl_cmd = 2'b10; fl_n = 3'd7; step();
    chk("set_all", 32'(sk_pf), 32'b111111);
    fl_cmd = 2'b01; fl_n = 3'd3; step();
    chk("clr_f3", 32'(sk_pf), 32'b111011);
    fl_cmd = 2'b11; fl_n = 3'd7; step();
    chk("rsv_nop", 32'(sk_pf), 32'b111011);
    fl_cmd = 2'b01; fl_n = 3'd0; step();
    chk("n0_nop", 32'(sk_pf), 32'b111011);
    fl_cmd = 2'b00;

    // szf 3 (flag 3 clear) then inverted, back-to-back
    sk_req = 1'b1; sk_mask = 12'd3; sk_i = 1'b0; step();
    chk("szf3_ack", 32'(sk_ack), 32'd1);
    chk("szf3_skp", 32'(sk_skp), 32'd1);
    sk_i = 1'b1; step();
    chk("szf3i_ack", 32'(sk_ack), 32'd1);
    chk("szf3i_skp", 32'(sk_skp), 32'd0);
    sk_req = 1'b0; sk_i = 1'b0; step();
    chk("idle_ack", 32'(sk_ack), 32'd0);
    chk("idle_skp", 32'(sk_skp), 32'd0);

    // szf 7 with a flag clear -> skip; szf 0 -> no skip
    req_chk("szf7", 12'd7, 1'b0, 1'b1, 1'b0);
    req_chk("szf0", 12'd0, 1'b0, 1'b0, 1'b0);

    // Same-cycle flag clear uses the old snapshot
    fl_cmd = 2'b10; fl_n = 3'd7; step();
    fl_cmd = 2'b01; fl_n = 3'd2;
    req_chk("szf2_snap", 12'd2, 1'b0, 1'b0, 1'b0);
    fl_cmd = 2'b00;
    chk("szf2_pf", 32'(sk_pf), 32'b111101);

    // Switch sync window: change then request the next cycle
    sk_sw = 6'b000100; step();
    req_chk("szs3_old", 12'o0030, 1'b0, 1'b1, 1'b0);
    step(); step();
    req_chk("szs3_new", 12'o0030, 1'b0, 1'b0, 1'b0);
    req_chk("szs7", 12'o0070, 1'b0, 1'b1, 1'b0);

    // sza then spa back-to-back
    sk_ac = 18'o0; sk_req = 1'b1; sk_mask = 12'o0100; sk_i = 1'b0; step();
    chk("sza_ack", 32'(sk_ack), 32'd1);
    chk("sza_skp", 32'(sk_skp), 32'd1);
    sk_ac = 18'o400000; sk_mask = 12'o0200; step();
    sk_req = 1'b0;
    chk("spa_ack", 32'(sk_ack), 32'd1);
    chk("spa_skp", 32'(sk_skp), 32'd0);
    req_chk("sma", 12'o0400, 1'b0, 1'b1, 1'b0);

    // Pending result unaffected by later input change
    sk_ac = 18'o0; sk_req = 1'b1; sk_mask = 12'o0100; step();
    sk_req = 1'b0; sk_ac = 18'o000007; #2;
    chk("hold_skp", 32'(sk_skp), 32'd1);
    step();
    chk("hold_drop", 32'(sk_skp), 32'd0);

    // szo with overflow on / off / inverted
    sk_ov = 1'b1;
    req_chk("szo_ov1", 12'o1000, 1'b0, 1'b0, OVCLR_EN);
    sk_ov = 1'b0;
    req_chk("szo_ov0", 12'o1000, 1'b0, 1'b1, OVCLR_EN);
    sk_ov = 1'b1;
    req_chk("szo_inv", 12'o1000, 1'b1, 1'b1, OVCLR_EN);

    // spi and PDP-1D sni
    sk_io = 18'o000000;
    req_chk("spi", 12'o2000, 1'b0, 1'b1, 1'b0);
    sk_io = 18'o000001;
    req_chk("sni_nz", 12'o4000, 1'b0, 1'b1, 1'b0);
    sk_io = 18'o400000;
    req_chk("sni_b0", 12'o4000, 1'b0, 1'b0, 1'b0);

    // Reset coincident with request and flag command
    sk_req = 1'b1; sk_mask = 12'o0100; sk_ac = 18'o0;
    fl_cmd = 2'b10; fl_n = 3'd7; rst = 1'b1; step();
    chk("rstmid_ack", 32'(sk_ack), 32'd0);
    chk("rstmid_skp", 32'(sk_skp), 32'd0);
    chk("rstmid_pf", 32'(sk_pf), 32'h0);
    rst = 1'b0; sk_req = 1'b0; fl_cmd = 2'b00; step();
    chk("post_rst_ack", 32'(sk_ack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
